// File: rtl/apb_manager.sv
// APB manager: bridges a simple generic-bus requester onto an APB bus.
// A request accepted in IDLE is address-decoded into one of PrphNum
// subordinate regions and then driven through the SETUP and ACCESS phases.
// Optional feature macro: APB_MANAGER_TIMEOUT_EN adds an ACCESS-phase
// watchdog that ends a stalled transfer with an error after TimeoutCycles.
module apb_manager #(
    parameter int                   DataWidth     = 32,
    parameter int                   AddrWidth     = 32,
    parameter int                   ProtWidth     = 4,
    parameter int                   PrphNum       = 2,
    parameter logic [AddrWidth-1:0] BaseAddr      = 'h100,
    parameter int                   RegionBits    = 8,
    parameter int                   TimeoutCycles = 16
) (
    input  logic                     clk,
    input  logic                     nReset,
    input  logic                     req_wEn,
    input  logic                     req_rEn,
    input  logic [AddrWidth-1:0]     req_addr,
    input  logic [DataWidth-1:0]     req_wData,
    input  logic [DataWidth/8-1:0]   req_wStrb,
    input  logic [ProtWidth-1:0]     req_prot,
    output logic [DataWidth-1:0]     req_rData,
    output logic                     req_error,
    output logic                     req_busy,
    output logic                     bus_write,
    output logic                     bus_enable,
    output logic [AddrWidth-1:0]     bus_addr,
    output logic [DataWidth-1:0]     bus_wData,
    output logic [DataWidth/8-1:0]   bus_strb,
    output logic [ProtWidth-1:0]     bus_prot,
    output logic [PrphNum-1:0]       bus_selectors,
    input  logic [DataWidth-1:0]     bus_rData,
    input  logic                     bus_subError,
    input  logic                     bus_ready
);

    localparam int StrbWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [DataWidth-1:0] r_rData;
    logic                 r_error;
    logic                 r_busy;
    logic                 r_write;
    logic                 r_enable;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wData;
    logic [StrbWidth-1:0] r_strb;
    logic [ProtWidth-1:0] r_prot;
    logic [PrphNum-1:0]   r_sel;

    logic [DataWidth-1:0] w_rDataNext;
    logic                 w_errorNext;
    logic                 w_busyNext;
    logic                 w_writeNext;
    logic                 w_enableNext;
    logic [AddrWidth-1:0] w_addrNext;
    logic [DataWidth-1:0] w_wDataNext;
    logic [StrbWidth-1:0] w_strbNext;
    logic [ProtWidth-1:0] w_protNext;
    logic [PrphNum-1:0]   w_selNext;

    logic [AddrWidth-1:0] w_offset;
    logic [AddrWidth-1:0] w_idx;
    logic                 w_decErr;
    logic [PrphNum-1:0]   w_sel;
    logic                 w_oneReq;
    logic                 w_bothReq;

`ifdef APB_MANAGER_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cntNext;
`endif

    assign w_oneReq  = req_wEn ^ req_rEn;
    assign w_bothReq = req_wEn & req_rEn;

    // Decode the incoming address into a one-hot subordinate select
    // (addresses below the base or beyond the last region are errors).
    always_comb begin
        w_offset = req_addr - BaseAddr;
        w_idx    = w_offset >> RegionBits;
        w_decErr = (req_addr < BaseAddr) || (w_idx >= AddrWidth'(PrphNum));
        w_sel    = '0;
        for (int i = 0; i < PrphNum; i++) begin
            w_sel[i] = (w_idx == AddrWidth'(i));
        end
    end

    // Next-state and next-output logic; error is a pulse, so it defaults low.
    always_comb begin
        w_stateNext  = r_state;
        w_rDataNext  = r_rData;
        w_errorNext  = 1'b0;
        w_busyNext   = r_busy;
        w_writeNext  = r_write;
        w_enableNext = r_enable;
        w_addrNext   = r_addr;
        w_wDataNext  = r_wData;
        w_strbNext   = r_strb;
        w_protNext   = r_prot;
        w_selNext    = r_sel;
`ifdef APB_MANAGER_TIMEOUT_EN
        w_cntNext    = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                w_busyNext   = 1'b0;
                w_enableNext = 1'b0;
                w_selNext    = '0;
                if (w_bothReq) begin
                    w_errorNext = 1'b1;
                end else if (w_oneReq) begin
                    if (w_decErr) begin
                        w_errorNext = 1'b1;
                    end else begin
                        w_addrNext  = req_addr;
                        w_wDataNext = req_wData;
                        w_strbNext  = req_wEn ? req_wStrb : '0;
                        w_protNext  = req_prot;
                        w_writeNext = req_wEn;
                        w_selNext   = w_sel;
                        w_busyNext  = 1'b1;
                        w_stateNext = SETUP;
                    end
                end
            end
            SETUP: begin
                w_enableNext = 1'b1;
                w_stateNext  = ACCESS;
`ifdef APB_MANAGER_TIMEOUT_EN
                w_cntNext    = '0;
`endif
            end
            ACCESS: begin
                if (bus_ready) begin
                    if (!r_write) begin
                        w_rDataNext = bus_rData;
                    end
                    w_errorNext  = bus_subError;
                    w_busyNext   = 1'b0;
                    w_selNext    = '0;
                    w_enableNext = 1'b0;
                    w_stateNext  = IDLE;
                end
`ifdef APB_MANAGER_TIMEOUT_EN
                else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
                    w_errorNext  = 1'b1;
                    w_busyNext   = 1'b0;
                    w_selNext    = '0;
                    w_enableNext = 1'b0;
                    w_stateNext  = IDLE;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Registered requester response and APB request outputs.
    always_ff @(posedge clk) begin
        if (nReset) begin
            r_rData  <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b0;
            r_write  <= 1'b0;
            r_enable <= 1'b0;
            r_addr   <= '0;
            r_wData  <= '0;
            r_strb   <= '0;
            r_prot   <= '0;
            r_sel    <= '0;
        end else begin
            r_rData  <= w_rDataNext;
            r_error  <= w_errorNext;
            r_busy   <= w_busyNext;
            r_write  <= w_writeNext;
            r_enable <= w_enableNext;
            r_addr   <= w_addrNext;
            r_wData  <= w_wDataNext;
            r_strb   <= w_strbNext;
            r_prot   <= w_protNext;
            r_sel    <= w_selNext;
        end
    end

`ifdef APB_MANAGER_TIMEOUT_EN
    // ACCESS-phase cycle counter for the watchdog.
    always_ff @(posedge clk) begin
        if (nReset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cntNext;
        end
    end
`endif

    assign req_rData     = r_rData;
    assign req_error     = r_error;
    assign req_busy      = r_busy;
    assign bus_write     = r_write;
    assign bus_enable    = r_enable;
    assign bus_addr      = r_addr;
    assign bus_wData     = r_wData;
    assign bus_strb      = r_strb;
    assign bus_prot      = r_prot;
    assign bus_selectors = r_sel;

endmodule

// File: tb/tb_apb_manager.sv
// Testbench for apb_manager: directed transfers with a response scoreboard.
// Define APB_MANAGER_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_apb_manager;

    logic        clk = 1'b0;
    logic        nReset = 1'b1;
    logic        req_wEn = 1'b0;
    logic        req_rEn = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wData = '0;
    logic [3:0]  req_wStrb = '0;
    logic [3:0]  req_prot = '0;
    logic [31:0] req_rData;
    logic        req_error;
    logic        req_busy;
    logic        bus_write;
    logic        bus_enable;
    logic [31:0] bus_addr;
    logic [31:0] bus_wData;
    logic [3:0]  bus_strb;
    logic [3:0]  bus_prot;
    logic [1:0]  bus_selectors;
    logic [31:0] bus_rData = '0;
    logic        bus_subError = 1'b0;
    logic        bus_ready = 1'b1;

    apb_manager dut (
        .clk          (clk),
        .nReset       (nReset),
        .req_wEn      (req_wEn),
        .req_rEn      (req_rEn),
        .req_addr     (req_addr),
        .req_wData    (req_wData),
        .req_wStrb    (req_wStrb),
        .req_prot     (req_prot),
        .req_rData    (req_rData),
        .req_error    (req_error),
        .req_busy     (req_busy),
        .bus_write    (bus_write),
        .bus_enable   (bus_enable),
        .bus_addr     (bus_addr),
        .bus_wData    (bus_wData),
        .bus_strb     (bus_strb),
        .bus_prot     (bus_prot),
        .bus_selectors(bus_selectors),
        .bus_rData    (bus_rData),
        .bus_subError (bus_subError),
        .bus_ready    (bus_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rData;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    resp_t       expQ[$];
    resp_t       monExp;
    logic [31:0] expRData = '0;
    logic        rstAtEdge = 1'b1;
    logic        prevBusy = 1'b0;
    int          accCycles;
    int          drainWait;

    // Remember whether the DUT saw reset at the last edge.
    always @(posedge clk) rstAtEdge <= nReset;

    // Response monitor: a busy fall or an idle error pulse is one response.
    always @(negedge clk) begin
        if (rstAtEdge) begin
            prevBusy <= 1'b0;
        end else begin
            if ((prevBusy && !req_busy) || (req_error && !req_busy)) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_response error=%0b rData=%h required none",
                             req_error, req_rData);
                end else begin
                    monExp = expQ.pop_front();
                    if (req_error !== monExp.err || req_rData !== monExp.rData) begin
                        errors++;
                        $display("[TB] FAIL response error=%0b rData=%h required error=%0b rData=%h",
                                 req_error, req_rData, monExp.err, monExp.rData);
                    end
                end
            end
            prevBusy <= req_busy;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Present a request for one cycle; returns just after the capturing edge.
    task automatic applyStimulus(input logic wEn, input logic rEn, input logic [31:0] addr,
                                 input logic [31:0] wData, input logic [3:0] strb,
                                 input logic [3:0] prot);
        @(posedge clk);
        #1;
        req_wEn   = wEn;
        req_rEn   = rEn;
        req_addr  = addr;
        req_wData = wData;
        req_wStrb = strb;
        req_prot  = prot;
        @(posedge clk);
        #1;
        req_wEn = 1'b0;
        req_rEn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", req_busy, 0);
        checkOutput("reset_error", req_error, 0);
        checkOutput("reset_rData", req_rData, 0);
        checkOutput("reset_sel", bus_selectors, 0);
        checkOutput("reset_enable", bus_enable, 0);
        checkOutput("reset_addr", bus_addr, 0);
        nReset = 1'b0;

        $display("[TB] write 0xDEADBEEF to 0x104");
        expQ.push_back('{err: 1'b0, rData: expRData});
        applyStimulus(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 4'hF, 4'h0);
        @(negedge clk);
        checkOutput("wr_setup_sel", bus_selectors, 2'b01);
        checkOutput("wr_setup_enable", bus_enable, 0);
        checkOutput("wr_setup_write", bus_write, 1);
        checkOutput("wr_setup_addr", bus_addr, 32'h104);
        checkOutput("wr_setup_wData", bus_wData, 32'hDEADBEEF);
        checkOutput("wr_setup_busy", req_busy, 1);
        @(negedge clk);
        checkOutput("wr_access_enable", bus_enable, 1);
        checkOutput("wr_access_sel", bus_selectors, 2'b01);
        checkOutput("wr_access_strb", bus_strb, 4'hF);
        @(negedge clk);
        checkOutput("wr_done_busy", req_busy, 0);
        checkOutput("wr_done_error", req_error, 0);
        checkOutput("wr_done_enable", bus_enable, 0);
        checkOutput("wr_done_sel", bus_selectors, 0);

        $display("[TB] read 0x208 with four wait cycles");
        bus_ready = 1'b0;
        bus_rData = 32'h12345678;
        expRData  = 32'h12345678;
        expQ.push_back('{err: 1'b0, rData: expRData});
        applyStimulus(1'b0, 1'b1, 32'h208, 32'hA5A5A5A5, 4'hF, 4'h5);
        @(negedge clk);
        checkOutput("rd_setup_sel", bus_selectors, 2'b10);
        checkOutput("rd_setup_enable", bus_enable, 0);
        checkOutput("rd_setup_strb", bus_strb, 0);
        checkOutput("rd_setup_write", bus_write, 0);
        checkOutput("rd_setup_prot", bus_prot, 4'h5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rd_access_enable", bus_enable, 1);
            checkOutput("rd_access_sel", bus_selectors, 2'b10);
            checkOutput("rd_access_addr", bus_addr, 32'h208);
            checkOutput("rd_access_strb", bus_strb, 0);
            checkOutput("rd_access_write", bus_write, 0);
            checkOutput("rd_access_busy", req_busy, 1);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        checkOutput("rd_done_busy", req_busy, 0);
        checkOutput("rd_done_rData", req_rData, 32'h12345678);
        bus_rData = 32'hCAFEF00D;

        $display("[TB] decode errors");
        expQ.push_back('{err: 1'b1, rData: expRData});
        applyStimulus(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        checkOutput("dec_hi_error", req_error, 1);
        checkOutput("dec_hi_busy", req_busy, 0);
        checkOutput("dec_hi_sel", bus_selectors, 0);
        checkOutput("dec_hi_enable", bus_enable, 0);
        @(negedge clk);
        checkOutput("dec_hi_error_end", req_error, 0);
        checkOutput("dec_hi_enable_after", bus_enable, 0);
        expQ.push_back('{err: 1'b1, rData: expRData});
        applyStimulus(1'b0, 1'b1, 32'h0FF, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        checkOutput("dec_lo_error", req_error, 1);
        checkOutput("dec_lo_sel", bus_selectors, 0);
        checkOutput("dec_lo_enable", bus_enable, 0);
        @(negedge clk);
        checkOutput("dec_lo_error_end", req_error, 0);
        checkOutput("dec_lo_enable_after", bus_enable, 0);

        $display("[TB] write with subordinate error");
        bus_subError = 1'b1;
        expQ.push_back('{err: 1'b1, rData: expRData});
        applyStimulus(1'b1, 1'b0, 32'h1F0, 32'h00000042, 4'h3, 4'h0);
        @(negedge clk);
        checkOutput("suberr_setup_sel", bus_selectors, 2'b01);
        checkOutput("suberr_setup_strb", bus_strb, 4'h3);
        @(negedge clk);
        checkOutput("suberr_access_enable", bus_enable, 1);
        @(negedge clk);
        checkOutput("suberr_error", req_error, 1);
        checkOutput("suberr_rData_kept", req_rData, 32'h12345678);
        @(negedge clk);
        checkOutput("suberr_error_end", req_error, 0);
        bus_subError = 1'b0;

        $display("[TB] simultaneous read and write");
        expQ.push_back('{err: 1'b1, rData: expRData});
        applyStimulus(1'b1, 1'b1, 32'h104, 32'h11111111, 4'hF, 4'h0);
        @(negedge clk);
        checkOutput("both_error", req_error, 1);
        checkOutput("both_busy", req_busy, 0);
        checkOutput("both_sel", bus_selectors, 0);
        @(negedge clk);
        checkOutput("both_error_end", req_error, 0);
        checkOutput("both_enable", bus_enable, 0);
        checkOutput("both_sel_after", bus_selectors, 0);

        $display("[TB] reset during ACCESS");
        bus_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h22222222, 4'hF, 4'h7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_access_enable", bus_enable, 1);
        nReset = 1'b1;
        @(negedge clk);
        nReset = 1'b0;
        expRData = '0;
        checkOutput("rst_busy", req_busy, 0);
        checkOutput("rst_error", req_error, 0);
        checkOutput("rst_rData", req_rData, 0);
        checkOutput("rst_enable", bus_enable, 0);
        checkOutput("rst_sel", bus_selectors, 0);
        checkOutput("rst_addr", bus_addr, 0);
        checkOutput("rst_wData", bus_wData, 0);
        checkOutput("rst_strb", bus_strb, 0);
        checkOutput("rst_prot", bus_prot, 0);
        checkOutput("rst_write", bus_write, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_no_pulse", req_error, 0);
        end

`ifdef APB_MANAGER_TIMEOUT_EN
        $display("[TB] ACCESS timeout");
        expQ.push_back('{err: 1'b1, rData: expRData});
        applyStimulus(1'b0, 1'b1, 32'h104, 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        accCycles = 0;
        while (accCycles < 40) begin
            @(negedge clk);
            accCycles++;
            if (!req_busy) break;
        end
        checkOutput("timeout_access_cycles", accCycles - 1, 16);
        checkOutput("timeout_error", req_error, 1);
        checkOutput("timeout_enable", bus_enable, 0);
`endif

        drainWait = 0;
        while (expQ.size() != 0 && drainWait < 20) begin
            @(negedge clk);
            drainWait++;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
